spram_ctrl: RTL and testbench
=============================

SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width and a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port enable, input, 1, request valid.
REQ-006 SHALL have port wr_en, input, 1, write when 1 and read when 0, sampled with enable.
REQ-007 SHALL have port addr, input, ADDR_W, word address.
REQ-008 SHALL have port data_in, input, DATA_W, write data.
REQ-009 SHALL have port byte_en, input, DATA_W/8, per-byte write enable, bit i gating data_in[8i+7:8i].
REQ-010 SHALL have port ready, output, 1, high when a request is accepted this cycle.
REQ-011 SHALL have port data_out, output, DATA_W, read data.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse marking data_out valid.
REQ-013 SHALL have port init_done, output, 1, high once the post-reset memory clear completes.

Function
REQ-014 SHALL implement an FSM with states INIT and IDLE.
REQ-015 INIT SHALL write zero to one word per cycle, addresses 0 to DEPTH-1, then enter IDLE; INIT lasts exactly DEPTH cycles.
REQ-016 ready and init_done SHALL be 0 in INIT and 1 in IDLE.
REQ-017 A request SHALL be accepted only on a cycle with enable=1 and ready=1.
REQ-018 enable during INIT SHALL be ignored: no memory change, no rd_valid, no queued request.
REQ-019 An accepted write SHALL update only bytes with byte_en=1, at that clock edge; byte_en=0 makes it a no-op.
REQ-020 Writes SHALL NOT change data_out or pulse rd_valid.
REQ-021 An accepted read SHALL drive data_out and pulse rd_valid exactly one cycle later (latency 1).
REQ-022 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Back-to-back reads SHALL be accepted every cycle, giving one rd_valid per read in order.
REQ-024 data_out SHALL hold the last read value until the next read completes.
REQ-025 Address decode SHALL be full; no address is out of range.

Reset
REQ-026 While reset=0 at a clock edge, the FSM SHALL enter INIT with the clear counter at 0. Outputs SHALL be ready=0, init_done=0, rd_valid=0 and data_out=0.
REQ-027 Reset during INIT or with a read in flight SHALL drop the pending rd_valid and restart the clear from address 0.

Configuration
REQ-028 Macro SPRAM_PARITY_EN SHALL add even parity: one stored bit per byte, written with the data and cleared to 0 in INIT.
REQ-029 With SPRAM_PARITY_EN, the block SHALL add output par_err (1 bit). par_err pulses together with rd_valid when any enabled byte's recomputed parity mismatches. It resets to 0.
REQ-030 Without SPRAM_PARITY_EN, there SHALL be no par_err port and no parity storage.

Structure
REQ-031 Package spram_pkg SHALL hold the FSM state typedef (INIT, IDLE) and the default DATA_W/ADDR_W constants.
REQ-032 Storage SHALL be a sub-module spram_array with a byte-enabled synchronous write and a registered read. spram_ctrl holds the FSM, clear counter and handshake.

Verification
REQ-033 Reset, then hold enable=1 read: ready=0 for 16 cycles, no rd_valid; then init_done=1 and the read of addr 0 returns 8'h00.
REQ-034 With DATA_W=32: write addr 3 = 32'hAABBCCDD with byte_en=4'hF, then write 32'h11223344 with byte_en=4'b0101, then read addr 3 -> data_out=32'hAA22CC44 one cycle after acceptance.
REQ-035 Write addr 5 = 8'h5A, then read addr 5 the next cycle -> 8'h5A. Then reads of addr 5,6,7 on consecutive cycles -> three consecutive rd_valid pulses.
REQ-036 Drive reset=0 one cycle after a read is accepted -> no rd_valid; after reset, INIT repeats and the previously written addr 5 reads 8'h00.
REQ-037 With SPRAM_PARITY_EN: write 8'h0F, force the stored parity bit to invert, read -> par_err=1 coincident with rd_valid. A clean read -> par_err=0.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared types and default sizing for the spram_ctrl single-port RAM controller.
package spram_pkg;

    localparam int unsigned SPRAM_DATA_W = 8;
    localparam int unsigned SPRAM_ADDR_W = 4;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } spram_state_e;

endpackage : spram_pkg

// File: rtl/spram_array.sv
// Byte-enabled single-port storage with a registered read port.
// Optional per-byte even parity storage/checking under SPRAM_PARITY_EN.
module spram_array
    import spram_pkg::*;
#(
    parameter int unsigned DATA_W = SPRAM_DATA_W,
    parameter int unsigned ADDR_W = SPRAM_ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o
`ifdef SPRAM_PARITY_EN
    ,
    output logic                par_err_o
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

`ifdef SPRAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] par_mis;
    logic          par_err_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    par_q[addr_i][b] <= ^wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Recompute parity of the addressed word; only bytes enabled on the read are reported.
    always_comb begin
        par_mis = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            par_mis[b] = (^mem_q[addr_i][8*b +: 8]) ^ par_q[addr_i][b];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= re_i && (|(par_mis & be_i));
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule : spram_array

// File: rtl/spram_ctrl.sv
// Single-port RAM controller: clears memory after reset, then serves
// byte-enabled writes and latency-1 reads. Define SPRAM_PARITY_EN for parity.
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int unsigned DATA_W = SPRAM_DATA_W,
    parameter int unsigned ADDR_W = SPRAM_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic                ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                init_done
`ifdef SPRAM_PARITY_EN
    ,
    output logic                par_err
`endif
);

    spram_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;

    logic                mem_we;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            INIT: begin
                clr_d = clr_q + ADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Storage accesses are gated by reset so an in-flight request is dropped.
    always_comb begin
        ready     = 1'b0;
        init_done = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr;
        mem_wdata = data_in;
        mem_be    = byte_en;
        case (state_q)
            INIT: begin
                mem_we    = reset;
                mem_addr  = clr_q;
                mem_wdata = '0;
                mem_be    = '1;
            end
            IDLE: begin
                ready     = 1'b1;
                init_done = 1'b1;
                mem_we    = reset & enable & wr_en;
                mem_re    = reset & enable & ~wr_en;
            end
            default: ;
        endcase
    end

    spram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (mem_we),
        .re_i      (mem_re),
        .addr_i    (mem_addr),
        .wdata_i   (mem_wdata),
        .be_i      (mem_be),
        .rdata_o   (data_out),
        .rvalid_o  (rd_valid)
`ifdef SPRAM_PARITY_EN
        ,
        .par_err_o (par_err)
`endif
    );

endmodule : spram_ctrl

// File: tb/tb_spram_ctrl.sv
// Scoreboard bench for spram_ctrl (DATA_W=32, ADDR_W=4); parity checks under SPRAM_PARITY_EN.
module tb_spram_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        par;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  byte_en = '0;
    logic        ready;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        init_done;
`ifdef SPRAM_PARITY_EN
    logic        par_err;
`endif

    int unsigned chk_cnt = 0;
    int unsigned pass_cnt = 0;
    int unsigned rv_run = 0;
    int unsigned rv_run_max = 0;
    exp_t        sb [$];

    spram_ctrl #(
        .DATA_W (32),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_en     (wr_en),
        .addr      (addr),
        .data_in   (data_in),
        .byte_en   (byte_en),
        .ready     (ready),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .init_done (init_done)
`ifdef SPRAM_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rv_run++;
            if (rv_run > rv_run_max) rv_run_max = rv_run;
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", data_out, e.data);
`ifdef SPRAM_PARITY_EN
                check("par_err", {31'd0, par_err}, {31'd0, e.par});
`endif
            end
        end else begin
            rv_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        enable = 1'b1; wr_en = 1'b1; addr = a; data_in = d; byte_en = be;
        tick();
        enable = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp_d, input logic exp_p);
        exp_t e;
        enable = 1'b1; wr_en = 1'b0; addr = a; byte_en = 4'hF;
        if (ready === 1'b1) begin
            e.data = exp_d;
            e.par  = exp_p;
            sb.push_back(e);
        end
        tick();
        enable = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        enable = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        int unsigned hi_cnt;

        // Reset state
        tick(); tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data_out", data_out, 32'd0);

        // Reset in the middle of INIT restarts the clear
        reset = 1'b1;
        idle(5);
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Hold a read request through INIT: exactly 16 cycles of ready=0, none accepted
        enable = 1'b1; wr_en = 1'b0; addr = 4'd0; byte_en = 4'hF;
        hi_cnt = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (ready !== 1'b0 || init_done !== 1'b0) hi_cnt++;
            tick();
        end
        check("init_ready_low_16", hi_cnt, 32'd0);
        check("init_done_after", {31'd0, init_done}, 32'd1);
        check("ready_after", {31'd0, ready}, 32'd1);
        do_read(4'd0, 32'h0000_0000, 1'b0);
        idle(2);

        // Byte enables
        do_write(4'd3, 32'hAABBCCDD, 4'hF);
        do_write(4'd3, 32'h11223344, 4'b0101);
        do_read(4'd3, 32'hAA22CC44, 1'b0);
        do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
        do_read(4'd3, 32'hAA22CC44, 1'b0);
        idle(1);
        check("hold_after_read", data_out, 32'hAA22CC44);
        do_write(4'd15, 32'hDEADBEEF, 4'hF);
        check("write_keeps_data_out", data_out, 32'hAA22CC44);
        check("write_no_rd_valid", {31'd0, rd_valid}, 32'd0);
        do_read(4'd15, 32'hDEADBEEF, 1'b0);
        idle(2);

        // Read-after-write and back-to-back reads
        do_write(4'd6, 32'h0000_0066, 4'hF);
        do_write(4'd7, 32'h0000_0077, 4'hF);
        do_write(4'd5, 32'h0000_005A, 4'hF);
        do_read(4'd5, 32'h0000_005A, 1'b0);
        idle(2);
        rv_run_max = 0;
        do_read(4'd5, 32'h0000_005A, 1'b0);
        do_read(4'd6, 32'h0000_0066, 1'b0);
        do_read(4'd7, 32'h0000_0077, 1'b0);
        idle(3);
        check("b2b_rd_valid_run", rv_run_max, 32'd3);
        check("hold_last_read", data_out, 32'h0000_0077);

`ifdef SPRAM_PARITY_EN
        do_write(4'd9, 32'h0000_000F, 4'hF);
        dut.u_array.par_q[9][0] = ~dut.u_array.par_q[9][0];
        do_read(4'd9, 32'h0000_000F, 1'b1);
        do_read(4'd3, 32'hAA22CC44, 1'b0);
        idle(2);
`endif

        // Reset sampled together with a read: no rd_valid, clear repeats
        enable = 1'b1; wr_en = 1'b0; addr = 4'd5; byte_en = 4'hF;
        reset = 1'b0;
        tick();
        check("rst_drop_rd_valid", {31'd0, rd_valid}, 32'd0);
        enable = 1'b0;
        tick();
        check("rst2_ready", {31'd0, ready}, 32'd0);
        check("rst2_data_out", data_out, 32'd0);
        reset = 1'b1;
        idle(16);
        check("reinit_done", {31'd0, init_done}, 32'd1);
        do_read(4'd5, 32'h0000_0000, 1'b0);

        for (int unsigned i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_spram_ctrl
